// File: rtl/slow_clock_monitor_pkg.sv
// Shared types and defaults for the slow clock monitor.
// The abs-difference helper works on 32-bit values, which covers any practical CNT_W.
package slow_clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRST   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TOL         = 1;
    localparam int DEF_TIMEOUT     = 64;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a prev register.
// It produces combinational single-cycle rise and fall events for any slow asynchronous input.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_last;

    assign s_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= s_last;
        end
    end

    assign rise_o = s_last & ~prev_q;
    assign fall_o = ~s_last & prev_q;

endmodule

// File: rtl/slow_clock_monitor.sv
// Measures a slow clock in the clk_100MHz domain.
// Outputs edge ticks, the period and high time, and lock/loss status.
module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TOL         = DEF_TOL,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             clk_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int               LOCK_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT - 1);

    logic rise_evt, fall_evt;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_100MHz),
        .rst_i  (reset),
        .d_i    (clk_in),
        .rise_o (rise_evt),
        .fall_o (fall_evt)
    );

    logic [CNT_W-1:0] cyc_q, cyc_d, hi_q, hi_d, idle_q, idle_d;

    always_comb begin
        cyc_d  = cyc_q;
        hi_d   = hi_q;
        idle_d = idle_q;
        if (rise_evt) begin
            cyc_d = CNT_W'(1);
            hi_d  = CNT_W'(1);
        end else begin
            if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_W'(1);
            if (hi_q  != CNT_MAX) hi_d  = hi_q  + CNT_W'(1);
        end
        if (rise_evt || fall_evt)  idle_d = '0;
        else if (idle_q != CNT_MAX) idle_d = idle_q + CNT_W'(1);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cyc_q  <= '0;
            hi_q   <= '0;
            idle_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            hi_q   <= hi_d;
            idle_q <= idle_d;
        end
    end

    // An edge in the terminal-count cycle takes priority, so no loss is declared then.
    logic timeout, p_ok;
    logic [CNT_W-1:0]  ref_q;
    logic [LOCK_W-1:0] match_q, match_inc;
    state_e            state_q;

    assign timeout   = (idle_q == TO_TERM) && !rise_evt && !fall_evt;
    assign p_ok      = (abs_diff(32'(cyc_q), 32'(ref_q)) <= 32'(TOL)) && (cyc_q != CNT_MAX);
    assign match_inc = match_q + LOCK_W'(1);

    logic             rise_tick_q, fall_tick_q, period_valid_q, locked_q, lost_q;
    logic [CNT_W-1:0] period_q, high_time_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ref_q          <= '0;
            match_q        <= '0;
            rise_tick_q    <= 1'b0;
            fall_tick_q    <= 1'b0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            rise_tick_q    <= rise_evt;
            fall_tick_q    <= fall_evt;
            period_valid_q <= 1'b0;
            lost_q         <= 1'b0;
            if (timeout && state_q != ST_IDLE) begin
                state_q     <= ST_IDLE;
                lost_q      <= 1'b1;
                locked_q    <= 1'b0;
                period_q    <= '0;
                high_time_q <= '0;
                match_q     <= '0;
            end else begin
                if (fall_evt && (state_q == ST_ACQUIRE || state_q == ST_LOCKED))
                    high_time_q <= hi_q;
                if (rise_evt) begin
                    case (state_q)
                        ST_IDLE: state_q <= ST_FIRST;
                        ST_FIRST: begin
                            period_q       <= cyc_q;
                            period_valid_q <= 1'b1;
                            ref_q          <= cyc_q;
                            match_q        <= '0;
                            state_q        <= ST_ACQUIRE;
                        end
                        ST_ACQUIRE: begin
                            period_q       <= cyc_q;
                            period_valid_q <= 1'b1;
                            if (p_ok) begin
                                match_q <= match_inc;
                                if (match_inc == LOCK_W'(LOCK_COUNT)) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                ref_q   <= cyc_q;
                                match_q <= '0;
                            end
                        end
                        ST_LOCKED: begin
                            period_q       <= cyc_q;
                            period_valid_q <= 1'b1;
                            // ref is frozen while locked so that cumulative drift breaks lock.
                            if (!p_ok) begin
                                locked_q <= 1'b0;
                                ref_q    <= cyc_q;
                                match_q  <= '0;
                                state_q  <= ST_ACQUIRE;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign rise_tick    = rise_tick_q;
    assign fall_tick    = fall_tick_q;
    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor: directed and random clk_in waveforms.
// Every cycle is checked against a model built from edge times and a window of matching periods.
module tb_slow_clock_monitor;

    localparam int LOCK = 4;
    localparam int TO   = 64;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       clk_in     = 1'b0;
    logic       rise_tick, fall_tick, period_valid, locked, lost;
    logic [7:0] period, high_time;

    always #5 clk_100MHz = ~clk_100MHz;

    slow_clock_monitor dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .clk_in       (clk_in),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    int total = 0, bad = 0;
    int cyc_no = 0, nrise = 0, last_rise = 0, last_edge = 0;
    int rt_cnt = 0, lock_at = 0, lost_cnt = 0, lk_drop = 0;
    logic [3:0] hist = '0;   // hist[k] = clk_in sampled k edges ago
    int win[$];              // periods matching win[0] since it was taken
    logic e_rise = 0, e_fall = 0, e_pv = 0, e_locked = 0, e_lost = 0;
    int   e_period = 0, e_high = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    function automatic int sat(input int d);
        return (d > 255) ? 255 : d;
    endfunction

    task automatic model_step();
        logic rt, ft;
        int p, d;
        cyc_no++;
        if (reset) begin
            hist = '0; nrise = 0; win.delete();
            {e_rise, e_fall, e_pv, e_locked, e_lost} = '0;
            e_period = 0; e_high = 0;
            return;
        end
        hist = {hist[2:0], clk_in};
        rt = hist[2] & ~hist[3];
        ft = ~hist[2] & hist[3];
        e_rise = rt; e_fall = ft; e_pv = 0; e_lost = 0;
        if (rt) begin
            if (nrise >= 1) begin
                p = sat(cyc_no - last_rise);
                e_period = p; e_pv = 1;
                d = (win.size() == 0) ? 999 : ((p > win[0]) ? p - win[0] : win[0] - p);
                if (d > 1 || p == 255) win.delete();
                win.push_back(p);
                e_locked = (win.size() > LOCK);
            end
            nrise++; last_rise = cyc_no; last_edge = cyc_no;
        end
        if (ft) begin
            if (nrise >= 2) e_high = sat(cyc_no - last_rise);
            last_edge = cyc_no;
        end
        if (!rt && !ft && nrise >= 1 && (cyc_no - last_edge) == TO) begin
            e_lost = 1; nrise = 0; win.delete();
            e_locked = 0; e_period = 0; e_high = 0;
        end
    endtask

    task automatic cyc(input logic v);
        @(negedge clk_100MHz); clk_in = v;
        @(posedge clk_100MHz); #1;
        model_step();
        chk("rise_tick", 32'(rise_tick), 32'(e_rise));
        chk("fall_tick", 32'(fall_tick), 32'(e_fall));
        chk("period", 32'(period), 32'(e_period));
        chk("high_time", 32'(high_time), 32'(e_high));
        chk("period_valid", 32'(period_valid), 32'(e_pv));
        chk("locked", 32'(locked), 32'(e_locked));
        chk("lost", 32'(lost), 32'(e_lost));
        if (rise_tick) rt_cnt++;
        if (locked && lock_at == 0) lock_at = rt_cnt;
        if (lost) lost_cnt++;
        if (!locked) lk_drop++;
    endtask

    task automatic wave(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0);
    endtask

    task automatic marks_clear();
        rt_cnt = 0; lock_at = 0; lost_cnt = 0; lk_drop = 0;
    endtask

    initial begin
        // Reset held while clk_in toggles.
        for (int i = 0; i < 6; i++) wave(2, 2);
        @(negedge clk_100MHz); clk_in = 1'b0; reset = 1'b0;
        marks_clear();

        // Steady period 4 from reset: lock on the 6th rise tick.
        for (int i = 0; i < 8; i++) wave(2, 2);
        chk("lock_at_rise6", 32'(lock_at), 32'd6);

        // Jitter within tolerance keeps lock.
        lk_drop = 0;
        for (int i = 0; i < 3; i++) begin
            wave(3, 2); wave(2, 2); wave(2, 1); wave(2, 2);
        end
        chk("lock_held_jitter", 32'(lk_drop), 32'd0);

        // Switch to period 8: unlock, relock 4 rises later.
        for (int i = 0; i < 7; i++) wave(4, 4);
        chk("relock_p8", 32'(locked), 32'd1);
        chk("period_p8", 32'(period), 32'd8);

        // Back to 4, then stall low: exactly one loss pulse.
        for (int i = 0; i < 8; i++) wave(2, 2);
        lost_cnt = 0;
        wave(0, 150);
        chk("lost_once", 32'(lost_cnt), 32'd1);
        chk("period_cleared", 32'(period), 32'd0);
        marks_clear();
        for (int i = 0; i < 8; i++) wave(2, 2);
        chk("relock_after_loss", 32'(lock_at), 32'd6);

        // Async reset mid-high phase while locked.
        cyc(1'b1);
        @(posedge clk_100MHz); #3; reset = 1'b1; #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high", 32'(high_time), 32'd0);
        chk("rst_ticks", 32'({rise_tick, fall_tick, period_valid, lost}), 32'd0);
        cyc(1'b1); cyc(1'b0);
        @(negedge clk_100MHz); reset = 1'b0;
        marks_clear();
        for (int i = 0; i < 8; i++) wave(2, 2);
        chk("relock_after_reset", 32'(lock_at), 32'd6);

        // Random waveforms with occasional long stalls.
        for (int i = 0; i < 250; i++) begin
            int hi, lo;
            hi = $urandom_range(1, 6);
            lo = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 6);
            if ($urandom_range(0, 3) != 0) begin
                hi = 2; lo = ($urandom_range(0, 1) == 0) ? 2 : lo;
            end
            wave(hi, lo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
